// File: rtl/div_issue_ctrl.sv
// Request front-end for the 32-bit multi-cycle unsigned divider core: queues tagged
// requests, issues them one at a time as magnitudes and sign-corrects the result.
module div_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [31:0]      in_dividend,
    input  logic [31:0]      in_divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_quotient,
    output logic [31:0]      out_remainder,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_dbz,
    output logic             div_start,
    output logic [31:0]      div_dividend,
    output logic [31:0]      div_divisor,
    input  logic [31:0]      div_quotient,
    input  logic [31:0]      div_remainder,
    input  logic             div_done
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = 1 + 32 + 32 + TAG_W;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    logic [EW-1:0]    r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;

    state_t           r_state;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_out_valid;
    logic [31:0]      r_out_quotient;
    logic [31:0]      r_out_remainder;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_dbz;
    logic             r_div_start;
    logic [31:0]      r_div_dividend;
    logic [31:0]      r_div_divisor;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [EW-1:0]    w_head;
    logic             w_head_signed;
    logic [31:0]      w_head_dividend;
    logic [31:0]      w_head_divisor;
    logic [TAG_W-1:0] w_head_tag;

    function automatic logic [31:0] magnitude(input logic is_signed, input logic [31:0] value);
        return (is_signed && value[31]) ? (~value + 32'd1) : value;
    endfunction

    assign w_full   = (r_count == (PW+1)'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_push   = in_valid && !w_full;
    assign w_pop    = (r_state == IDLE) && !w_empty;
    assign in_ready = !w_full;

    assign w_head          = r_mem[r_rd_ptr];
    assign w_head_signed   = w_head[EW-1];
    assign w_head_dividend = w_head[EW-2 -: 32];
    assign w_head_divisor  = w_head[TAG_W+31 -: 32];
    assign w_head_tag      = w_head[TAG_W-1:0];

    // Entry layout: {signed, dividend, divisor, tag}; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {in_signed, in_dividend, in_divisor, in_tag};
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Divide-by-zero never reaches the core; it is answered straight from IDLE.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state         <= IDLE;
            r_neg_q         <= 1'b0;
            r_neg_r         <= 1'b0;
            r_out_valid     <= 1'b0;
            r_out_quotient  <= '0;
            r_out_remainder <= '0;
            r_out_tag       <= '0;
            r_out_dbz       <= 1'b0;
            r_div_start     <= 1'b0;
            r_div_dividend  <= '0;
            r_div_divisor   <= '0;
        end else begin
            r_div_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_out_tag <= w_head_tag;
                        r_neg_q   <= w_head_signed && (w_head_dividend[31] ^ w_head_divisor[31]);
                        r_neg_r   <= w_head_signed && w_head_dividend[31];
                        if (w_head_divisor == 32'd0) begin
                            r_out_quotient  <= 32'hFFFF_FFFF;
                            r_out_remainder <= w_head_dividend;
                            r_out_dbz       <= 1'b1;
                            r_out_valid     <= 1'b1;
                            r_state         <= RESP;
                        end else begin
                            r_div_dividend <= magnitude(w_head_signed, w_head_dividend);
                            r_div_divisor  <= magnitude(w_head_signed, w_head_divisor);
                            r_div_start    <= 1'b1;
                            r_state        <= ISSUE;
                        end
                    end
                end
                ISSUE: r_state <= WAIT;
                WAIT: begin
                    if (div_done) begin
                        r_out_quotient  <= r_neg_q ? (32'd0 - div_quotient) : div_quotient;
                        r_out_remainder <= r_neg_r ? (32'd0 - div_remainder) : div_remainder;
                        r_out_dbz       <= 1'b0;
                        r_out_valid     <= 1'b1;
                        r_state         <= RESP;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid     = r_out_valid;
    assign out_quotient  = r_out_quotient;
    assign out_remainder = r_out_remainder;
    assign out_tag       = r_out_tag;
    assign out_dbz       = r_out_dbz;
    assign div_start     = r_div_start;
    assign div_dividend  = r_div_dividend;
    assign div_divisor   = r_div_divisor;

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
Request front-end that sits directly upstream of the 32-bit multi-cycle unsigned divider core. It buffers tagged divide requests in a small FIFO and issues one at a time to the core with a single-cycle start pulse. It converts signed operands to magnitudes, waits for the core's done pulse, sign-corrects the result and returns it on a valid/ready response port. Divide-by-zero is resolved locally without occupying the core.

Parameters:
DEPTH, 4, request FIFO depth in entries (power of two, >=2)
TAG_W, 4, width of the request tag carried through to the response

Ports:
clk  input  1  clock, all logic on rising edge
rstn  input  1  synchronous reset, active-high; name kept as in the codebase, asserted = 1
in_valid  input  1  request valid
in_ready  output  1  request FIFO can accept
in_signed  input  1  1 = two's-complement operands, 0 = unsigned
in_dividend  input  32  dividend
in_divisor  input  32  divisor
in_tag  input  TAG_W  request tag
out_valid  output  1  response valid
out_ready  input  1  consumer accepts response
out_quotient  output  32  final quotient
out_remainder  output  32  final remainder
out_tag  output  TAG_W  tag of the request being answered
out_dbz  output  1  response came from the divide-by-zero path
div_start  output  1  one-cycle start pulse to the core
div_dividend  output  32  magnitude dividend to the core, held stable from start until done
div_divisor  output  32  magnitude divisor to the core, held stable from start until done
div_quotient  input  32  core quotient, valid with div_done
div_remainder  input  32  core remainder, valid with div_done
div_done  input  1  core completion pulse

Behaviour:
- Reset, sampled on clk while rstn=1: FIFO empty; state IDLE; out_valid, out_dbz, div_start = 0; out_quotient, out_remainder, out_tag, div_dividend, div_divisor = 0. in_ready = 1 in the first cycle after reset.
- Reset mid-operation discards all queued and in-flight requests. The core shares rstn.
- FIFO:
  - in_ready = !full.
  - A push occurs when in_valid && in_ready.
  - When the FIFO is full, no push is accepted, even in a cycle that also pops.
  - Pop and push in the same cycle are allowed when not full; count is unchanged.
  - Read and write pointers wrap modulo DEPTH.
- FSM, states IDLE, ISSUE, WAIT, RESP:
  - IDLE, FIFO non-empty: pop the head and latch signed flag, tag and operand signs.
    - If divisor == 0: load the response register and go to RESP with out_dbz = 1.
    - Otherwise: load div_dividend and div_divisor with the magnitudes and go to ISSUE.
  - IDLE, FIFO empty: stay in IDLE.
  - ISSUE: div_start = 1 for exactly this cycle, then go to WAIT.
  - WAIT: on div_done, apply sign correction, load the response register, set out_valid = 1 and go to RESP.
  - RESP: out_valid and the response fields are held stable until out_valid && out_ready. Then out_valid = 0 and go to IDLE; no pop happens in that same cycle.
- div_done is ignored in any state other than WAIT.
- Magnitudes: if signed and bit31 = 1, the operand is negated (two's complement, 32-bit); otherwise it is passed unchanged.
- Sign correction, signed requests only:
  - quotient is negated when dividend sign != divisor sign;
  - remainder is negated when dividend is negative.
- Overflow case -2^31 / -1 needs no special handling: quotient = 0x80000000, remainder = 0.
- Divide-by-zero response (signed and unsigned): quotient = 0xFFFFFFFF, remainder = dividend unchanged, out_dbz = 1.
- Latency, request pushed at edge N into an empty FIFO with the FSM in IDLE:
  - pop at N+1;
  - div_start high in cycle N+2;
  - out_valid high the cycle after div_done is sampled;
  - for the divide-by-zero path, out_valid high at N+2.
- Only one request is in flight at a time. Responses return in request order.

Test Plan:
- Unsigned 100/7, tag 3 -> div_start pulses exactly once with div_dividend 100 and div_divisor 7; response quotient 14, remainder 2, tag 3, out_dbz 0.
- Signed -100/7 (0xFFFFFF9C/7) -> core sees 100/7; response quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2). Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- Divisor 0, dividend 0x1234 -> out_valid at N+2 with quotient 0xFFFFFFFF, remainder 0x1234, out_dbz 1, and div_start never asserted.
- Push 5 requests back-to-back with out_ready=0 and a core with done latency 6 -> in_ready drops after the FIFO is full. Release out_ready -> all 5 responses arrive in tag order 0..4, none lost or duplicated.
- Hold out_ready=0 for 10 cycles during RESP -> out_quotient, out_remainder, out_tag and out_valid stay stable throughout, and no new div_start is issued.
- Assert rstn during WAIT with 3 entries queued -> next cycle out_valid 0, in_ready 1, FIFO empty; a later stray div_done produces no response.
